// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset PC and fetch types for the control path
package cpu_pkg;

    localparam int CPU_ADDR_WIDTH = 32;
    localparam int CPU_DATA_WIDTH = 32;
    localparam logic [CPU_ADDR_WIDTH-1:0] CPU_RESET_PC = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [CPU_DATA_WIDTH-1:0] instr;
        logic [CPU_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry registered FIFO of fetched instructions
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Storage and pointers; flush wins over a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Head of queue is presented straight from storage.
    always_comb begin
        head  = mem_q[rd_ptr_q];
        count = count_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem request issue, branch redirect and fetch buffering
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(CPU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] ImmOp
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] issued_pc_q;
    logic                  inflight_q;

    logic                  pop;
    logic                  redirect_now;
    logic                  issue;
    logic                  push;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] target;
    logic [1:0]            buf_count;
    fetch_entry_t          buf_head;
    fetch_entry_t          push_entry;

    // Handshake, redirect decision and the slot accounting that gates issue.
    always_comb begin
        instr_valid  = (buf_count != 2'd0);
        instr        = DATA_WIDTH'(buf_head.instr);
        instr_pc     = ADDR_WIDTH'(buf_head.pc);
        pop          = instr_valid && instr_ready;
        redirect_now = pop && PCSrc;
        target       = (instr_pc + ImmOp) & ~ADDR_WIDTH'(3);
        occupancy    = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
        issue        = !rst && (occupancy < 3'd2) && !redirect_now;
        push_entry.instr = CPU_DATA_WIDTH'(imem_rdata);
        push_entry.pc    = CPU_ADDR_WIDTH'(issued_pc_q);
    end

    // FSM state register plus PC and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                issued_pc_q <= fetch_pc_q;
            end
            if (redirect_now) begin
                fetch_pc_q <= target;
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(INSTR_BYTES);
            end
        end
    end

    // FLUSH lasts one cycle, only needed when a response is still on its way.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (redirect_now && inflight_q) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: responses are only kept in RUN; the request address is the fetch PC.
    always_comb begin
        push      = inflight_q && (state_q == RUN);
        imem_req  = issue;
        imem_addr = fetch_pc_q;
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_now),
        .push_entry (push_entry),
        .count      (buf_count),
        .head       (buf_head)
    );

endmodule
